// File: rtl/cache_bus_responder.sv
// Memory-side responder for the instruction-cache bus port: grants the bus, runs a wrapping
// line-fill burst or a single write-through beat. Optional macro FILL_TIMEOUT_EN adds a per-beat abort.
module cache_bus_responder #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk0,
  input  logic        reset,
  input  logic        bus_request,
  output logic        bus_grant,
  input  logic [23:0] bus_addr,
  input  logic [2:0]  bus_cmd,
  input  logic [31:0] bus_datain,
  output logic [31:0] bus_dataout,
  output logic        bus_data_valid,
  output logic        bus_done,
  output logic        bus_error,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  output logic [2:0]  mem_cmd,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int L = $clog2(BURST_LEN);

  if (BURST_LEN < 2 || BURST_LEN > 32 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_len
    $error("BURST_LEN must be a power of two in 2..32");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, GRANT, CAPTURE, READ, WRITE, DONE} state_t;

  state_t        state;
  logic [23:0]   base;
  logic [L-1:0]  beat;
  logic          err;

`ifdef FILL_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] wait_cnt;
`endif

  // Critical-word-first: the low L bits wrap inside the aligned block.
  function automatic logic [23:0] wrap_addr(input logic [23:0] b, input logic [L-1:0] k);
    logic [L-1:0] lo;
    lo = b[L-1:0] + k;
    return {b[23:L], lo};
  endfunction

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      base           <= '0;
      beat           <= '0;
      err            <= 1'b0;
      bus_grant      <= 1'b0;
      bus_dataout    <= '0;
      bus_data_valid <= 1'b0;
      bus_done       <= 1'b0;
      bus_error      <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      mem_cmd        <= 3'b000;
      mem_wdata      <= '0;
`ifdef FILL_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      bus_data_valid <= 1'b0;
      bus_done       <= 1'b0;
      bus_error      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_request) begin
            bus_grant <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: state <= CAPTURE;
        CAPTURE: begin
          base      <= bus_addr;
          mem_addr  <= bus_addr;
          mem_wdata <= bus_datain;
          beat      <= '0;
`ifdef FILL_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
          case (bus_cmd)
            3'b001: begin
              mem_req <= 1'b1;
              mem_cmd <= 3'b001;
              state   <= READ;
            end
            3'b010: begin
              mem_req <= 1'b1;
              mem_cmd <= 3'b010;
              state   <= WRITE;
            end
            default: begin
              err   <= 1'b1;
              state <= DONE;
            end
          endcase
        end
        READ: begin
          if (mem_ack) begin
            bus_dataout    <= mem_rdata;
            bus_data_valid <= 1'b1;
`ifdef FILL_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
            if (beat == L'(BURST_LEN - 1)) begin
              mem_req <= 1'b0;
              state   <= DONE;
            end else begin
              beat     <= beat + L'(1);
              mem_addr <= wrap_addr(base, beat + L'(1));
            end
          end
`ifdef FILL_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
          end
`ifdef FILL_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        DONE: begin
          bus_grant <= 1'b0;
          bus_done  <= 1'b1;
          bus_error <= err;
          err       <= 1'b0;
          mem_cmd   <= 3'b000;
          beat      <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_responder.sv
// Scoreboard bench for cache_bus_responder: fills, write, illegal command, reset abort, timeout.
module tb_cache_bus_responder;
  localparam int BL = 4;
  localparam int TO = 8;

  logic        clk0 = 1'b0;
  logic        reset;
  logic        bus_request;
  logic        bus_grant;
  logic [23:0] bus_addr;
  logic [2:0]  bus_cmd;
  logic [31:0] bus_datain;
  logic [31:0] bus_dataout;
  logic        bus_data_valid;
  logic        bus_done;
  logic        bus_error;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [2:0]  mem_cmd;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int errors  = 0;
  logic [23:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  cache_bus_responder #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk0(clk0), .reset(reset), .bus_request(bus_request), .bus_grant(bus_grant),
    .bus_addr(bus_addr), .bus_cmd(bus_cmd), .bus_datain(bus_datain),
    .bus_dataout(bus_dataout), .bus_data_valid(bus_data_valid), .bus_done(bus_done),
    .bus_error(bus_error), .mem_req(mem_req), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk0 = ~clk0;

  function automatic logic [23:0] model_addr(input logic [23:0] b, input int k);
    int lo;
    lo = (int'(b[1:0]) + k) % BL;
    return {b[23:2], 2'(lo)};
  endfunction

  function automatic logic all_zero();
    return (bus_grant === 1'b0) && (bus_data_valid === 1'b0) && (bus_done === 1'b0) &&
           (bus_error === 1'b0) && (mem_req === 1'b0) && (bus_dataout === 32'h0) &&
           (mem_addr === 24'h0) && (mem_wdata === 32'h0) && (mem_cmd === 3'b000);
  endfunction

  task automatic test_reset();
    reset = 1'b1; bus_request = 1'b1; bus_cmd = 3'b001; bus_addr = 24'h0; bus_datain = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk0);
    vectors++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL reset_values grant=%b req=%b addr=%h cmd=%b expected all zero", bus_grant, mem_req, mem_addr, mem_cmd);
    end
    bus_request = 1'b0;
    reset = 1'b0;
    @(negedge clk0);
    vectors++;
    if (bus_grant !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_grant grant=%b expected 0", bus_grant);
    end
  endtask

  // stall: random ack stalls; drop: release request during beat 1; hold: keep request for back-to-back
  task automatic test_read_fill(input logic [23:0] base, input bit stall, input bit drop, input bit hold);
    int cyc = 0, words = 0, first_valid = -1, done_cyc = -1;
    bit stalled = 0;
    logic [23:0] held = '0;
    exp_addr_q.delete(); exp_data_q.delete();
    for (int k = 0; k < BL; k++) begin
      exp_addr_q.push_back(model_addr(base, k));
      exp_data_q.push_back({8'hA5, model_addr(base, k)});
    end
    bus_request = 1'b1; bus_cmd = 3'b001; bus_addr = base; bus_datain = 32'h12345678; mem_ack = 1'b0;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk0);
      cyc++;
      mem_ack = 1'b0;
      if (cyc == 1 || cyc == 2) begin
        vectors++;
        if (bus_grant !== 1'b1 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL grant_phase cyc=%0d grant=%b req=%b expected 1/0", cyc, bus_grant, mem_req);
        end
      end
      if (bus_data_valid) begin
        vectors++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word got %h expected none", bus_dataout);
        end else begin
          if (bus_dataout !== exp_data_q[0]) begin
            errors++;
            $display("FAIL fill_word%0d got %h expected %h", words, bus_dataout, exp_data_q[0]);
          end
          void'(exp_data_q.pop_front());
        end
        if (first_valid < 0) first_valid = cyc;
        words++;
      end
      if (mem_req) begin
        if (stalled) begin
          vectors++;
          if (mem_addr !== held) begin
            errors++;
            $display("FAIL addr_hold got %h expected %h", mem_addr, held);
          end
        end
        if (!stall || $urandom_range(0, 2) == 0) begin
          vectors++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat addr=%h expected no request", mem_addr);
          end else begin
            if (mem_addr !== exp_addr_q[0] || mem_cmd !== 3'b001) begin
              errors++;
              $display("FAIL beat_addr got %h/%b expected %h/001", mem_addr, mem_cmd, exp_addr_q[0]);
            end
            void'(exp_addr_q.pop_front());
          end
          mem_ack = 1'b1;
          mem_rdata = {8'hA5, mem_addr};
          stalled = 0;
        end else begin
          stalled = 1;
          held = mem_addr;
        end
      end
      if (drop && words == 1) bus_request = 1'b0;
      if (bus_done) done_cyc = cyc;
    end
    mem_ack = 1'b0;
    vectors++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL fill_timeout no bus_done within %0d cycles", cyc);
    end else if (words != BL || bus_error !== 1'b0 || bus_grant !== 1'b0 || mem_req !== 1'b0 ||
                 exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL fill_end words=%0d err=%b grant=%b req=%b expected %0d/0/0/0", words, bus_error, bus_grant, mem_req, BL);
    end
    if (!stall && done_cyc >= 0) begin
      vectors++;
      if (first_valid != 4 || done_cyc != 4 + BL) begin
        errors++;
        $display("FAIL fill_timing first=%0d done=%0d expected 4/%0d", first_valid, done_cyc, 4 + BL);
      end
    end
    if (!hold) bus_request = 1'b0;
  endtask

  task automatic test_write();
    int cyc = 0, waits = 0, ack_cyc = -1, done_cyc = -1;
    bus_request = 1'b1; bus_cmd = 3'b010; bus_addr = 24'h080010; bus_datain = 32'hDEADBEEF; mem_ack = 1'b0;
    while (done_cyc < 0 && cyc < 50) begin
      @(negedge clk0);
      cyc++;
      mem_ack = 1'b0;
      if (cyc == 2) bus_request = 1'b0;
      if (bus_data_valid) begin
        vectors++; errors++;
        $display("FAIL write_valid strobe at cyc=%0d expected none", cyc);
      end
      if (ack_cyc >= 0 && cyc == ack_cyc + 1) begin
        vectors++;
        if (mem_req !== 1'b0) begin
          errors++;
          $display("FAIL write_single_beat req=%b expected 0", mem_req);
        end
      end
      if (mem_req) begin
        vectors++;
        if (mem_addr !== 24'h080010 || mem_cmd !== 3'b010 || mem_wdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL write_beat got %h/%b/%h expected 080010/010/deadbeef", mem_addr, mem_cmd, mem_wdata);
        end
        if (waits < 3) waits++;
        else begin
          mem_ack = 1'b1;
          ack_cyc = cyc;
        end
      end
      if (bus_done) done_cyc = cyc;
    end
    mem_ack = 1'b0;
    vectors++;
    if (done_cyc < 0 || done_cyc != ack_cyc + 2 || bus_error !== 1'b0 || bus_grant !== 1'b0) begin
      errors++;
      $display("FAIL write_done done=%0d ack=%0d err=%b grant=%b expected done=ack+2, 0, 0", done_cyc, ack_cyc, bus_error, bus_grant);
    end
  endtask

  task automatic test_illegal();
    int cyc = 0, done_cyc = -1;
    bus_request = 1'b1; bus_cmd = 3'b111; bus_addr = 24'h000040; mem_ack = 1'b0;
    while (done_cyc < 0 && cyc < 20) begin
      @(negedge clk0);
      cyc++;
      if (cyc == 1) bus_request = 1'b0;
      if (mem_req) begin
        vectors++; errors++;
        $display("FAIL illegal_req mem_req=1 at cyc=%0d expected 0", cyc);
      end
      if (bus_done) done_cyc = cyc;
    end
    vectors++;
    if (done_cyc != 4 || bus_error !== 1'b1 || bus_grant !== 1'b0) begin
      errors++;
      $display("FAIL illegal_done done=%0d err=%b grant=%b expected 4/1/0", done_cyc, bus_error, bus_grant);
    end
    @(negedge clk0);
    vectors++;
    if (bus_grant !== 1'b0 || bus_done !== 1'b0 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after grant=%b done=%b err=%b expected 0/0/0", bus_grant, bus_done, bus_error);
    end
  endtask

  task automatic test_reset_mid_fill();
    int cyc = 0, words = 0;
    bus_request = 1'b1; bus_cmd = 3'b001; bus_addr = 24'h0002A3; bus_datain = 32'h55AA55AA; mem_ack = 1'b0;
    while (words < 2 && cyc < 50) begin
      @(negedge clk0);
      cyc++;
      mem_ack = 1'b0;
      if (bus_data_valid) words++;
      if (mem_req && words < 2) begin
        mem_ack = 1'b1;
        mem_rdata = {8'h3C, mem_addr};
      end
    end
    mem_ack = 1'b0;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (words != 2 || !all_zero()) begin
      errors++;
      $display("FAIL reset_async words=%0d grant=%b valid=%b req=%b data=%h expected 2 words then all zero", words, bus_grant, bus_data_valid, mem_req, bus_dataout);
    end
    bus_request = 1'b0;
    @(negedge clk0);
    reset = 1'b0;
    @(negedge clk0);
    vectors++;
    if (bus_grant !== 1'b0 || bus_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done grant=%b done=%b req=%b expected 0/0/0", bus_grant, bus_done, mem_req);
    end
  endtask

  task automatic test_timeout();
    int cyc = 0, req_cycles = 0, done_cyc = -1;
    bus_request = 1'b1; bus_cmd = 3'b001; bus_addr = 24'h000300; mem_ack = 1'b0;
`ifdef FILL_TIMEOUT_EN
    while (done_cyc < 0 && cyc < 100) begin
      @(negedge clk0);
      cyc++;
      if (cyc == 1) bus_request = 1'b0;
      if (mem_req) req_cycles++;
      if (bus_data_valid) begin
        vectors++; errors++;
        $display("FAIL timeout_valid strobe at cyc=%0d expected none", cyc);
      end
      if (bus_done) done_cyc = cyc;
    end
    vectors++;
    if (req_cycles != TO || done_cyc != TO + 4 || bus_error !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort req_cycles=%0d done=%0d err=%b expected %0d/%0d/1", req_cycles, done_cyc, bus_error, TO, TO + 4);
    end
`else
    repeat (40) begin
      @(negedge clk0);
      cyc++;
      if (cyc == 1) bus_request = 1'b0;
      if (mem_req) req_cycles++;
      if (bus_done) done_cyc = cyc;
    end
    vectors++;
    if (done_cyc >= 0 || mem_req !== 1'b1 || req_cycles != 38) begin
      errors++;
      $display("FAIL no_timeout done=%0d req=%b req_cycles=%0d expected none/1/38", done_cyc, mem_req, req_cycles);
    end
    #1 reset = 1'b1;
    @(negedge clk0);
    reset = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_read_fill(24'h000106, 1'b0, 1'b0, 1'b0);
    @(negedge clk0);
    test_write();
    @(negedge clk0);
    test_illegal();
    test_read_fill(24'h0A0F3D, 1'b1, 1'b1, 1'b0);
    @(negedge clk0);
    test_read_fill(24'h123458, 1'b0, 1'b0, 1'b1);
    test_read_fill(24'h00FFFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk0);
    test_reset_mid_fill();
    test_read_fill(24'h0002A3, 1'b0, 1'b0, 1'b0);
    @(negedge clk0);
    test_timeout();
    @(negedge clk0);
    test_read_fill(24'h7FFFF1, 1'b1, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
